// File: rtl/ckt_sched_pkg.sv
// Shared types and constants for the test-circuit access scheduler.
package ckt_sched_pkg;

    // Width of the circuit input vector (inputs a..h).
    localparam int VEC_W = 8;

    // Bit positions of the circuit inputs inside an 8-bit vector (a is the MSB).
    localparam int BIT_A = 7;
    localparam int BIT_B = 6;
    localparam int BIT_C = 5;
    localparam int BIT_D = 4;
    localparam int BIT_E = 3;
    localparam int BIT_F = 2;
    localparam int BIT_G = 1;
    localparam int BIT_H = 0;

    // Scheduler states: one transaction in flight at a time.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/ckt_access_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after the
// pointer, wrapping around. Purely combinational.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                gnt[j] = 1'b1;
                idx    = IW'(j);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ckt_access_sched.sv
// Shares one 8-input/2-output test circuit among NUM_REQ requesters.
// Handshake: a requester raises req with its vector on req_vec and holds both
// until it sees its gnt bit; gnt is only offered in IDLE and the vector is
// captured on the edge where gnt is high. The answer arrives later as a
// single-cycle rsp_valid strobe tagged with rsp_id; there is no back-pressure.
module ckt_access_sched
    import ckt_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*VEC_W-1:0]     req_vec,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [VEC_W-1:0]             ckt_in,
    input  logic                         ckt_o1,
    input  logic                         ckt_o2,
    output logic                         rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic                         rsp_o1,
    output logic                         rsp_o2,
    output logic                         rsp_mismatch,
    output logic                         busy,
    input  logic                         clr_stats,
    output logic                         mismatch_sticky,
    output logic [CNT_W-1:0]             mismatch_cnt,
    output logic [1:0]                   state_dbg
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int WW = $clog2(LATENCY + 1);

    state_t             state, state_n;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      id_q;
    logic [WW-1:0]      wait_cnt;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic [CNT_W-1:0]   cnt_n;
    logic               sticky_n;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state: grant starts a run, the last wait cycle moves to the response.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (arb_any) state_n = RUN;
            RUN:     if (wait_cnt == WW'(1)) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs decoded from state; grant is suppressed while reset is held.
    always_comb begin
        gnt       = (state == IDLE && !rst) ? arb_gnt : '0;
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
        state_dbg = state;
    end

    // Transaction datapath: capture vector on grant, count down, sample outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr          <= '0;
            id_q         <= '0;
            wait_cnt     <= '0;
            ckt_in       <= '0;
            rsp_id       <= '0;
            rsp_o1       <= 1'b0;
            rsp_o2       <= 1'b0;
            rsp_mismatch <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        ckt_in   <= req_vec[VEC_W*arb_idx +: VEC_W];
                        id_q     <= arb_idx;
                        wait_cnt <= WW'(LATENCY);
                        ptr      <= (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
                    end
                end
                RUN: begin
                    wait_cnt <= wait_cnt - WW'(1);
                    if (wait_cnt == WW'(1)) begin
                        rsp_o1       <= ckt_o1;
                        rsp_o2       <= ckt_o2;
                        rsp_mismatch <= ckt_o1 ^ ckt_o2;
                        rsp_id       <= id_q;
                    end
                end
                RESP: ckt_in <= '0;
                default: ckt_in <= '0;
            endcase
        end
    end

    // Statistics next value: clear takes effect first, then the response event.
    always_comb begin
        cnt_n    = clr_stats ? '0 : mismatch_cnt;
        sticky_n = clr_stats ? 1'b0 : mismatch_sticky;
        if (state == RESP && rsp_mismatch) begin
            sticky_n = 1'b1;
            if (cnt_n != '1) cnt_n = cnt_n + CNT_W'(1);
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_cnt    <= '0;
            mismatch_sticky <= 1'b0;
        end else begin
            mismatch_cnt    <= cnt_n;
            mismatch_sticky <= sticky_n;
        end
    end

endmodule

// File: tb/tb_ckt_access_sched.sv
// Bench for ckt_access_sched: transaction-level reference model, response
// scoreboard, directed scenarios followed by randomized traffic.
module tb_ckt_access_sched;

  localparam int N  = 4;
  localparam int L  = 2;
  localparam int CW = 2;
  localparam int W  = 5;  // {id[1:0], o1, o2, mismatch}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   req;
  logic [N*8-1:0] req_vec;
  logic [N-1:0]   gnt;
  logic [7:0]     ckt_in;
  logic           ckt_o1, ckt_o2;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic           rsp_o1, rsp_o2, rsp_mismatch, busy;
  logic           clr_stats;
  logic           mismatch_sticky;
  logic [CW-1:0]  mismatch_cnt;
  logic [1:0]     state_dbg;

  ckt_access_sched #(.NUM_REQ(N), .LATENCY(L), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_vec(req_vec), .gnt(gnt),
    .ckt_in(ckt_in), .ckt_o1(ckt_o1), .ckt_o2(ckt_o2),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_o1(rsp_o1), .rsp_o2(rsp_o2),
    .rsp_mismatch(rsp_mismatch), .busy(busy), .clr_stats(clr_stats),
    .mismatch_sticky(mismatch_sticky), .mismatch_cnt(mismatch_cnt),
    .state_dbg(state_dbg)
  );

  // ---------------- circuit under share: one register stage ----------------
  bit   force_mis;
  logic o1_r = 1'b0, o2_r = 1'b0;

  function automatic logic f_o1(input logic [7:0] v, input bit f);
    return f ? 1'b1 : ^v;
  endfunction

  function automatic logic f_o2(input logic [7:0] v, input bit f);
    return f ? 1'b0 : ((^v) ^ (v[7] & v[0]));
  endfunction

  always @(posedge clk) begin
    o1_r <= f_o1(ckt_in, force_mis);
    o2_r <= f_o2(ckt_in, force_mis);
  end
  assign ckt_o1 = o1_r;
  assign ckt_o2 = o2_r;

  // ---------------- counters / scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  int dut_gnt_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Shared resource is free every L+2 cycles; round-robin order from m_ptr.
  int         m_ptr = 0;
  int         m_busy = 0;      // remaining occupied cycles after the grant cycle
  logic [7:0] m_vec = '0;
  logic       m_mis = 1'b0;
  int         m_cnt = 0;
  logic       m_sticky = 1'b0;
  int         last_gnt = -1;   // requester granted at the coming edge (for the driver)
  bit         hold_all = 0;
  bit         rand_on = 0;
  int         rand_pct = 30;

  always @(negedge clk) begin
    if (!rst) begin
      logic [N-1:0] eg;
      int w;
      logic o1, o2;
      check("stat_cnt", 32'(mismatch_cnt), 32'(m_cnt));
      check("stat_sticky", 32'(mismatch_sticky), 32'(m_sticky));
      check("busy", 32'(busy), 32'(m_busy > 0));
      check("ckt_in", 32'(ckt_in), (m_busy > 0) ? 32'(m_vec) : 32'd0);
      check("rsp_valid", 32'(rsp_valid), 32'(m_busy == 1));
      for (int k = 0; k < N; k++) if (gnt[k]) dut_gnt_log.push_back(k);
      // statistics for the coming edge
      if (clr_stats) begin
        m_cnt = 0;
        m_sticky = 1'b0;
      end
      if (m_busy == 1 && m_mis) begin
        m_sticky = 1'b1;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
      // arbitration for the coming edge
      eg = '0;
      if (m_busy == 0) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        if (w >= 0) begin
          eg[w]  = 1'b1;
          m_vec  = req_vec[8*w +: 8];
          o1     = f_o1(m_vec, force_mis);
          o2     = f_o2(m_vec, force_mis);
          m_mis  = (o1 != o2);
          exp_q.push_back({2'(w), o1, o2, m_mis});
          m_ptr  = (w + 1) % N;
          m_busy = L + 1;
          last_gnt = w;
        end
      end else begin
        m_busy--;
      end
      check("gnt", 32'(gnt), 32'(eg));
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_unexpected: got id %0d expected no response", rsp_id);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e[4:3]));
        check("rsp_o1", 32'(rsp_o1), 32'(e[2]));
        check("rsp_o2", 32'(rsp_o2), 32'(e[1]));
        check("rsp_mismatch", 32'(rsp_mismatch), 32'(e[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic raise(input int i);
    req_vec[8*i +: 8] = 8'($urandom);
    req[i] = 1'b1;
  endtask

  task automatic cycle_step();
    @(posedge clk);
    #1;
    clr_stats = rand_on && ($urandom_range(0, 99) < 5);
    if (last_gnt >= 0) begin
      if (hold_all) raise(last_gnt);
      else req[last_gnt] = 1'b0;
      last_gnt = -1;
    end
    if (rand_on)
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 99) < rand_pct) raise(i);
  endtask

  task automatic cycles(input int n);
    repeat (n) cycle_step();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    m_busy = 0; m_ptr = 0; m_cnt = 0; m_sticky = 1'b0;
    last_gnt = -1;
    clr_stats = 1'b0;
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ckt_in", 32'(ckt_in), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp", 32'({rsp_id, rsp_o1, rsp_o2, rsp_mismatch}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stats", 32'({mismatch_sticky, mismatch_cnt}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((m_busy != 0 || req != '0 || last_gnt >= 0) && n < 60) begin
      cycle_step();
      n++;
    end
    check("drain_timeout", 32'(n < 60), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c3;
    rst = 1'b1; req = '0; req_vec = '0; clr_stats = 1'b0; force_mis = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // single request 2 with vector A5
    req_vec[23:16] = 8'hA5;
    req = 4'b0100;
    dut_gnt_log.delete();
    cycles(6);
    check("single_gnt_id", (dut_gnt_log.size() == 1) ? 32'(dut_gnt_log[0]) : 32'hFFFF, 32'd2);
    drain();

    // reset in the middle of a run while request 1 waits
    raise(1);
    raise(3);
    cycles(1);
    do_reset();
    dut_gnt_log.delete();
    raise(0);
    cycles(1);
    check("post_rst_gnt", (dut_gnt_log.size() == 1) ? 32'(dut_gnt_log[0]) : 32'hFFFF, 32'd0);
    drain();

    // all requesters held high: strict rotation
    do_reset();
    hold_all = 1;
    for (int i = 0; i < N; i++) raise(i);
    dut_gnt_log.delete();
    cycles(5 * (L + 2));
    hold_all = 0;
    req = '0;
    last_gnt = -1;
    check("rr_count", 32'(dut_gnt_log.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < dut_gnt_log.size(); k++)
      check("rr_order", 32'(dut_gnt_log[k]), 32'(k % N));
    drain();

    // forced disagreement: counter steps by one and saturates
    do_reset();
    force_mis = 1;
    for (int t = 0; t < 5; t++) begin
      raise(t % N);
      cycles(L + 3);
      check("sat_cnt", 32'(mismatch_cnt), (t + 1 > 3) ? 32'd3 : 32'(t + 1));
      check("sat_sticky", 32'(mismatch_sticky), 32'd1);
    end
    drain();
    // clear on the same cycle as a mismatching response
    raise(2);
    for (int k = 0; k < 10; k++) begin
      cycle_step();
      if (m_busy == 1) begin
        clr_stats = 1'b1;
        break;
      end
    end
    cycles(2);
    check("clr_resp_cnt", 32'(mismatch_cnt), 32'd1);
    check("clr_resp_sticky", 32'(mismatch_sticky), 32'd1);
    clr_stats = 1'b1;
    cycles(1);
    check("clr_cnt", 32'(mismatch_cnt), 32'd0);
    check("clr_sticky", 32'(mismatch_sticky), 32'd0);
    drain();
    force_mis = 0;

    // request 3 withdrawn while another requester runs
    do_reset();
    dut_gnt_log.delete();
    raise(0);
    cycles(1);
    raise(3);
    cycles(1);
    req[3] = 1'b0;
    cycles(6);
    c3 = 0;
    foreach (dut_gnt_log[k]) if (dut_gnt_log[k] == 3) c3++;
    check("drop_no_gnt3", 32'(c3), 32'd0);
    drain();

    // randomized traffic
    rand_on = 1;
    cycles(400);
    rand_on = 0;
    clr_stats = 1'b0;
    drain();

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
